// File: rtl/line_arb_pkg.sv
// rtl/line_arb_pkg.sv - shared state, owner and rw encodings for the line request arbiter
package line_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic OWN_IC   = 1'b0;
  localparam logic OWN_DC   = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int LINE_OFF_W = 4;

endpackage

// File: rtl/line_req_arb_if.sv
// rtl/line_req_arb_if.sv - cache request, response and axi_m request signals of the line arbiter
interface line_req_arb_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              ic_req_valid_i;
  logic [ADDR_W-1:0] ic_req_addr_i;
  logic              ic_req_ready_o;
  logic              ic_rsp_valid_o;
  logic [LINE_W-1:0] ic_rsp_data_o;

  logic              dc_req_valid_i;
  logic              dc_req_rw_i;
  logic [ADDR_W-1:0] dc_req_addr_i;
  logic [LINE_W-1:0] dc_req_data_i;
  logic              dc_req_ready_o;
  logic              dc_rsp_valid_o;
  logic [LINE_W-1:0] dc_rsp_data_o;

  logic              rsp_err_o;

  logic              rvcore_valid_req_o;
  logic              rvcore_rw_o;
  logic [ADDR_W-1:0] rvcore_addr_o;
  logic [LINE_W-1:0] rvcore_data_o;
  logic [LINE_W-1:0] axi_data_i;
  logic              axi_rd_over_i;
  logic              axi_wr_over_i;

  modport slave (
    input  ic_req_valid_i, ic_req_addr_i,
    input  dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_data_i,
    input  axi_data_i, axi_rd_over_i, axi_wr_over_i,
    output ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    output dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    output rsp_err_o,
    output rvcore_valid_req_o, rvcore_rw_o, rvcore_addr_o, rvcore_data_o
  );

  modport master (
    output ic_req_valid_i, ic_req_addr_i,
    output dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_data_i,
    output axi_data_i, axi_rd_over_i, axi_wr_over_i,
    input  ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    input  dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    input  rsp_err_o,
    input  rvcore_valid_req_o, rvcore_rw_o, rvcore_addr_o, rvcore_data_o
  );

endinterface

// File: rtl/line_arb_pick.sv
// rtl/line_arb_pick.sv - grant selection between I-cache and D-cache requests
// LINE_ARB_RR_EN selects round-robin on ties; otherwise D-cache has fixed priority.
module line_arb_pick
  import line_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_ic_valid,
  input  logic i_dc_valid,
  input  logic i_take,
  output logic o_grant_any,
  output logic o_owner
);

  assign o_grant_any = i_ic_valid | i_dc_valid;

`ifdef LINE_ARB_RR_EN
  logic r_last;

  // Reset to "I-cache last" so the first tie goes to the D-cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWN_IC;
    end else if (i_take && o_grant_any) begin
      r_last <= o_owner;
    end
  end

  always_comb begin
    o_owner = i_dc_valid ? OWN_DC : OWN_IC;
    if (i_ic_valid && i_dc_valid) begin
      o_owner = ~r_last;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_take};
  assign o_owner  = i_dc_valid ? OWN_DC : OWN_IC;
`endif

endmodule

// File: rtl/line_req_arb.sv
// rtl/line_req_arb.sv - serialises I/D-cache line requests onto axi_m with a completion watchdog
// Optional LINE_ARB_RR_EN: round-robin tie breaking in line_arb_pick.
module line_req_arb
  import line_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TMO_CYC = 1023
) (
  input  logic           clk,
  input  logic           rst,
  line_req_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_rw;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic w_idle;
  logic w_resp;
  logic w_both;
  logic w_grant_any;
  logic w_owner;
  logic w_done;
  logic w_tmo;

  assign w_idle = (r_state == ST_IDLE);
  assign w_resp = (r_state == ST_RESP);
  assign w_both = bus.ic_req_valid_i & bus.dc_req_valid_i;

  line_arb_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .i_ic_valid  (bus.ic_req_valid_i),
    .i_dc_valid  (bus.dc_req_valid_i),
    .i_take      (w_idle),
    .o_grant_any (w_grant_any),
    .o_owner     (w_owner)
  );

  // The tie loser's ready is dropped so its valid&ready never looks accepted.
  assign bus.ic_req_ready_o = w_idle & ~(w_both & (w_owner == OWN_DC));
  assign bus.dc_req_ready_o = w_idle & ~(w_both & (w_owner == OWN_IC));

  assign w_done = (r_rw == RW_READ) ? bus.axi_rd_over_i : bus.axi_wr_over_i;
  assign w_tmo  = (r_cnt == TMO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IC;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_owner <= w_owner;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_state <= ST_ISSUE;
            if (w_owner == OWN_DC) begin
              r_rw    <= bus.dc_req_rw_i;
              r_addr  <= {bus.dc_req_addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
              r_wdata <= (bus.dc_req_rw_i == RW_WRITE) ? bus.dc_req_data_i : '0;
            end else begin
              r_rw    <= RW_READ;
              r_addr  <= {bus.ic_req_addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
              r_wdata <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (w_done) begin
            if (r_rw == RW_READ) begin
              r_rdata <= bus.axi_data_i;
            end
            r_state <= ST_RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rvcore_valid_req_o = (r_state == ST_ISSUE);
  assign bus.rvcore_rw_o        = r_rw;
  assign bus.rvcore_addr_o      = r_addr;
  assign bus.rvcore_data_o      = r_wdata;

  assign bus.ic_rsp_valid_o = w_resp & (r_owner == OWN_IC);
  assign bus.dc_rsp_valid_o = w_resp & (r_owner == OWN_DC);
  assign bus.ic_rsp_data_o  = bus.ic_rsp_valid_o ? r_rdata : '0;
  assign bus.dc_rsp_data_o  = bus.dc_rsp_valid_o ? r_rdata : '0;
  assign bus.rsp_err_o      = w_resp & r_err;

endmodule

// File: tb/tb_line_req_arb.sv
// tb/tb_line_req_arb.sv - randomized self-checking bench for line_req_arb
module tb_line_req_arb;

  localparam int TMO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_last_dc = 1'b0;

  line_req_arb_if bus ();

  line_req_arb #(.ADDR_W(32), .LINE_W(128), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout sim did not finish, required finish");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ic_req_valid_i = 1'b0;
    bus.ic_req_addr_i  = '0;
    bus.dc_req_valid_i = 1'b0;
    bus.dc_req_rw_i    = 1'b0;
    bus.dc_req_addr_i  = '0;
    bus.dc_req_data_i  = '0;
    bus.axi_data_i     = '0;
    bus.axi_rd_over_i  = 1'b0;
    bus.axi_wr_over_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    m_last_dc = 1'b0;
  endtask

  // Drives one request until accepted; returns in the strobe cycle with s_cyc = its index.
  task automatic req(input bit dc, input bit rw, input logic [31:0] a,
                     input logic [127:0] d, output int s_cyc);
    bit got = 1'b0;
    if (dc) begin
      bus.dc_req_valid_i = 1'b1;
      bus.dc_req_rw_i    = rw;
      bus.dc_req_addr_i  = a;
      bus.dc_req_data_i  = d;
    end else begin
      bus.ic_req_valid_i = 1'b1;
      bus.ic_req_addr_i  = a;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      got = dc ? bus.dc_req_ready_o : bus.ic_req_ready_o;
      cyc();
      if (got) break;
    end
    bus.dc_req_valid_i = 1'b0;
    bus.ic_req_valid_i = 1'b0;
    #1;
    s_cyc = cyc_n;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL req_handshake ready=0 required=1 within 20 cycles");
    end
    m_last_dc = dc;
  endtask

  // Pulses completion inputs for one cycle (index m_cyc); returns sampled in cycle m_cyc+1.
  task automatic pulse(input bit rd, input bit wr, input logic [127:0] d, output int m_cyc);
    cyc();
    bus.axi_rd_over_i = rd;
    bus.axi_wr_over_i = wr;
    bus.axi_data_i    = d;
    m_cyc = cyc_n;
    cyc();
    bus.axi_rd_over_i = 1'b0;
    bus.axi_wr_over_i = 1'b0;
    bus.axi_data_i    = rnd128();
    #1;
  endtask

  task automatic test_reset();
    logic [521:0] outs;
    do_reset();
    #1;
    outs = {bus.ic_rsp_valid_o, bus.ic_rsp_data_o, bus.dc_rsp_valid_o, bus.dc_rsp_data_o,
            bus.rsp_err_o, bus.rvcore_valid_req_o, bus.rvcore_rw_o, bus.rvcore_addr_o,
            bus.rvcore_data_o};
    n_cmp++;
    if (bus.ic_req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ic_ready got=%b exp=1", bus.ic_req_ready_o);
    end
    n_cmp++;
    if (bus.dc_req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_dc_ready got=%b exp=1", bus.dc_req_ready_o);
    end
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%0h exp=0", outs);
    end
  endtask

  task automatic test_ic_read();
    int s, m;
    logic [127:0] rd;
    rd = {16{8'h03}};
    req(1'b0, 1'b1, 32'h0000_0014, '0, s);
    n_cmp++;
    if ({bus.rvcore_valid_req_o, bus.rvcore_rw_o} !== 2'b11) begin
      n_bad++; $display("FAIL ic_strobe_rw got=%b exp=11", {bus.rvcore_valid_req_o, bus.rvcore_rw_o});
    end
    n_cmp++;
    if (bus.rvcore_addr_o !== 32'h10) begin
      n_bad++; $display("FAIL ic_addr got=%0h exp=10", bus.rvcore_addr_o);
    end
    pulse(1'b1, 1'b0, rd, m);
    n_cmp++;
    if ({bus.ic_rsp_valid_o, bus.dc_rsp_valid_o, bus.rsp_err_o} !== 3'b100) begin
      n_bad++; $display("FAIL ic_rsp_flags got=%b exp=100",
                        {bus.ic_rsp_valid_o, bus.dc_rsp_valid_o, bus.rsp_err_o});
    end
    n_cmp++;
    if (bus.ic_rsp_data_o !== rd) begin
      n_bad++; $display("FAIL ic_rsp_data got=%0h exp=%0h", bus.ic_rsp_data_o, rd);
    end
    cyc();
    #1;
    n_cmp++;
    if ({bus.ic_rsp_valid_o, bus.ic_req_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL ic_after_rsp got=%b exp=01", {bus.ic_rsp_valid_o, bus.ic_req_ready_o});
    end
  endtask

  task automatic test_dc_write();
    int s, m;
    logic [127:0] wd;
    wd = {16{8'hA5}};
    req(1'b1, 1'b0, 32'h0000_0100, wd, s);
    n_cmp++;
    if ({bus.rvcore_valid_req_o, bus.rvcore_rw_o, bus.rvcore_addr_o} !== {2'b10, 32'h100}) begin
      n_bad++; $display("FAIL dc_wr_strobe got=%b/%0h exp=10/100",
                        {bus.rvcore_valid_req_o, bus.rvcore_rw_o}, bus.rvcore_addr_o);
    end
    n_cmp++;
    if (bus.rvcore_data_o !== wd) begin
      n_bad++; $display("FAIL dc_wr_data got=%0h exp=%0h", bus.rvcore_data_o, wd);
    end
    pulse(1'b1, 1'b0, rnd128(), m);
    n_cmp++;
    if ({bus.ic_rsp_valid_o, bus.dc_rsp_valid_o} !== 2'b00) begin
      n_bad++; $display("FAIL dc_stray_ignored got=%b exp=00", {bus.ic_rsp_valid_o, bus.dc_rsp_valid_o});
    end
    pulse(1'b0, 1'b1, rnd128(), m);
    n_cmp++;
    if ({bus.dc_rsp_valid_o, bus.rsp_err_o, bus.dc_rsp_data_o} !== {2'b10, 128'h0}) begin
      n_bad++; $display("FAIL dc_wr_rsp got=%b/%0h exp=10/0",
                        {bus.dc_rsp_valid_o, bus.rsp_err_o}, bus.dc_rsp_data_o);
    end
    cyc();
  endtask

  // Both requesters hold a queue of reads; the model picks each winner from the arbitration rules.
  task automatic test_tie();
    logic [31:0] qi[$];
    logic [31:0] qd[$];
    bit exp_dc;
    bit rr;
    int m;
    logic [31:0] ea;
    logic [127:0] rd;
`ifdef LINE_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      qi.push_back({1'b0, 31'($urandom())});
      qd.push_back({1'b1, 31'($urandom())});
    end
    for (int g = 0; g < 6 && (qi.size() != 0 || qd.size() != 0); g++) begin
      bus.ic_req_valid_i = (qi.size() != 0);
      bus.dc_req_valid_i = (qd.size() != 0);
      bus.dc_req_rw_i    = 1'b1;
      if (qi.size() != 0) bus.ic_req_addr_i = qi[0];
      if (qd.size() != 0) bus.dc_req_addr_i = qd[0];
      if (qd.size() == 0)      exp_dc = 1'b0;
      else if (qi.size() == 0) exp_dc = 1'b1;
      else                     exp_dc = rr ? ~m_last_dc : 1'b1;
      #1;
      if (qi.size() != 0 && qd.size() != 0) begin
        n_cmp++;
        if ((exp_dc ? bus.ic_req_ready_o : bus.dc_req_ready_o) !== 1'b0) begin
          n_bad++; $display("FAIL tie_loser_ready round=%0d got=1 exp=0", g);
        end
      end
      ea = exp_dc ? qd.pop_front() : qi.pop_front();
      m_last_dc = exp_dc;
      cyc();
      bus.ic_req_valid_i = (qi.size() != 0);
      bus.dc_req_valid_i = (qd.size() != 0);
      if (qi.size() != 0) bus.ic_req_addr_i = qi[0];
      if (qd.size() != 0) bus.dc_req_addr_i = qd[0];
      #1;
      n_cmp++;
      if ({bus.rvcore_valid_req_o, bus.rvcore_addr_o} !== {1'b1, ea & 32'hFFFF_FFF0}) begin
        n_bad++; $display("FAIL tie_grant round=%0d got=%b/%0h exp=1/%0h", g,
                          bus.rvcore_valid_req_o, bus.rvcore_addr_o, ea & 32'hFFFF_FFF0);
      end
      rd = rnd128();
      pulse(1'b1, 1'b0, rd, m);
      n_cmp++;
      if ({bus.dc_rsp_valid_o, bus.ic_rsp_valid_o} !== {exp_dc, ~exp_dc}) begin
        n_bad++; $display("FAIL tie_rsp_owner round=%0d got=%b exp=%b", g,
                          {bus.dc_rsp_valid_o, bus.ic_rsp_valid_o}, {exp_dc, ~exp_dc});
      end
      n_cmp++;
      if ((exp_dc ? bus.dc_rsp_data_o : bus.ic_rsp_data_o) !== rd) begin
        n_bad++; $display("FAIL tie_rsp_data round=%0d exp=%0h", g, rd);
      end
      cyc();
    end
    idle_in();
  endtask

  task automatic test_watchdog();
    int s;
    int r = -1;
    req(1'b0, 1'b1, $urandom(), '0, s);
    for (int i = 0; i < TMO + 20; i++) begin
      if (bus.ic_rsp_valid_o || bus.dc_rsp_valid_o) begin
        r = cyc_n;
        break;
      end
      cyc();
      #1;
    end
    n_cmp++;
    if (r - s !== TMO + 2) begin
      n_bad++; $display("FAIL wdog_latency got=%0d exp=%0d", r - s, TMO + 2);
    end
    n_cmp++;
    if ({bus.ic_rsp_valid_o, bus.rsp_err_o, bus.ic_rsp_data_o} !== {2'b11, 128'h0}) begin
      n_bad++; $display("FAIL wdog_rsp got=%b/%0h exp=11/0",
                        {bus.ic_rsp_valid_o, bus.rsp_err_o}, bus.ic_rsp_data_o);
    end
    cyc();
  endtask

  task automatic test_reset_in_wait();
    int s, m;
    bit seen = 1'b0;
    req(1'b1, 1'b1, $urandom(), '0, s);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_last_dc = 1'b0;
    pulse(1'b1, 1'b0, rnd128(), m);
    for (int i = 0; i < 4; i++) begin
      if (bus.ic_rsp_valid_o || bus.dc_rsp_valid_o || bus.rvcore_valid_req_o) seen = 1'b1;
      cyc();
      #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rst_late_completion got=activity exp=none");
    end
    n_cmp++;
    if ({bus.ic_req_ready_o, bus.dc_req_ready_o, bus.rsp_err_o, bus.rvcore_rw_o,
         bus.rvcore_addr_o, bus.rvcore_data_o} !== {2'b11, 2'b00, 32'h0, 128'h0}) begin
      n_bad++; $display("FAIL rst_outputs ready=%b%b rw=%b addr=%0h exp 11/0/0",
                        bus.ic_req_ready_o, bus.dc_req_ready_o, bus.rvcore_rw_o, bus.rvcore_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    int s, m;
    int t = -1;
    logic [127:0] wd;
    wd = rnd128();
    req(1'b1, 1'b0, $urandom(), wd, s);
    cyc();
    cyc();
    #1;
    n_cmp++;
    if (bus.rvcore_data_o !== wd) begin
      n_bad++; $display("FAIL b2b_wdata_hold got=%0h exp=%0h", bus.rvcore_data_o, wd);
    end
    pulse(1'b0, 1'b1, rnd128(), m);
    bus.dc_req_valid_i = 1'b1;
    bus.dc_req_rw_i    = 1'b1;
    bus.dc_req_addr_i  = $urandom();
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      if (bus.rvcore_valid_req_o) begin
        t = cyc_n;
        break;
      end
    end
    bus.dc_req_valid_i = 1'b0;
    m_last_dc = 1'b1;
    n_cmp++;
    if (t - m !== 3) begin
      n_bad++; $display("FAIL b2b_strobe_gap got=%0d exp=3", t - m);
    end
    pulse(1'b1, 1'b0, rnd128(), m);
    cyc();
  endtask

  task automatic test_random();
    int s, m;
    bit dc, rw;
    logic [31:0] a;
    logic [127:0] wd, rd, exp_d;
    for (int k = 0; k < 16; k++) begin
      dc = 1'($urandom());
      rw = dc ? 1'($urandom()) : 1'b1;
      a  = $urandom();
      wd = rnd128();
      rd = rnd128();
      req(dc, rw, a, wd, s);
      n_cmp++;
      if ({bus.rvcore_rw_o, bus.rvcore_addr_o} !== {rw, a & 32'hFFFF_FFF0}) begin
        n_bad++; $display("FAIL rnd_req k=%0d got=%b/%0h exp=%b/%0h", k, bus.rvcore_rw_o,
                          bus.rvcore_addr_o, rw, a & 32'hFFFF_FFF0);
      end
      if (!rw) begin
        n_cmp++;
        if (bus.rvcore_data_o !== wd) begin
          n_bad++; $display("FAIL rnd_wdata k=%0d got=%0h exp=%0h", k, bus.rvcore_data_o, wd);
        end
      end
      repeat ($urandom_range(0, 3)) cyc();
      if ($urandom_range(0, 1) == 1) begin
        pulse(~rw, rw, rnd128(), m);
        n_cmp++;
        if ({bus.ic_rsp_valid_o, bus.dc_rsp_valid_o} !== 2'b00) begin
          n_bad++; $display("FAIL rnd_stray k=%0d got=%b exp=00", k,
                            {bus.ic_rsp_valid_o, bus.dc_rsp_valid_o});
        end
      end
      pulse(rw, ~rw, rd, m);
      exp_d = rw ? rd : '0;
      n_cmp++;
      if ({bus.dc_rsp_valid_o, bus.ic_rsp_valid_o, bus.rsp_err_o} !== {dc, ~dc, 1'b0}) begin
        n_bad++; $display("FAIL rnd_rsp_flags k=%0d got=%b exp=%b", k,
                          {bus.dc_rsp_valid_o, bus.ic_rsp_valid_o, bus.rsp_err_o}, {dc, ~dc, 1'b0});
      end
      n_cmp++;
      if ((dc ? bus.dc_rsp_data_o : bus.ic_rsp_data_o) !== exp_d) begin
        n_bad++; $display("FAIL rnd_rsp_data k=%0d exp=%0h", k, exp_d);
      end
      cyc();
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_ic_read();
    test_dc_write();
    do_reset();
    test_tie();
    test_watchdog();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
